bit_deframer: RTL



---
 rtl/bit_deframer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bit_deframer.sv
// rtl/bit_deframer.sv - serial sync-hunting deframer with one-deep valid/ready output buffer
//
// Purpose: consumes one qualified serial bit per cycle, hunts for the SYNC
// header, assembles the following WIDTH bits (MSB first) into a word and
// presents it on a one-deep output buffer. A word completing while the buffer
// is still full is dropped and flagged in the sticky overflow bit.
//
// Optional feature macro: BIT_DEFRAMER_PARITY_EN
//   defined   - each frame carries a trailing even-parity bit; parity_err is
//               registered with every committed word.
//   undefined - no parity bit; parity_err is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   bit_in     in   serial bit
//   bit_en     in   bit_in is a valid new bit this cycle
//   data_out   out  assembled word, first-received bit is MSB
//   data_valid out  data_out holds an unconsumed word
//   data_ready in   consumer accepts the word this cycle
//   parity_err out  parity status of the buffered word
//   overflow   out  sticky: a completed word was dropped
//   busy       out  high in every state except HUNT

module bit_deframer #(
  parameter int                  WIDTH    = 8,
  parameter int                  SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0] SYNC     = 4'b1011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             parity_err,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Without parity the word register only has to remember WIDTH-1 bits: the
  // last bit goes straight from bit_in into the commit path.
`ifdef BIT_DEFRAMER_PARITY_EN
  localparam int WW = WIDTH;
`else
  localparam int WW = WIDTH - 1;
`endif

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1
`ifdef BIT_DEFRAMER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t              state_q;
  logic [SYNC_LEN-1:0] hist_q;
  logic [CW-1:0]       cnt_q;
  logic [WW-1:0]       word_q;
  logic [WIDTH-1:0]    data_out_q;
  logic                data_valid_q;
  logic                overflow_q;

  logic [SYNC_LEN-1:0] hist_shift;
  logic [WIDTH-1:0]    word_shift;
  logic                last_data;
  logic                commit;
  logic                can_load;
  logic [WIDTH-1:0]    data_out_d;

  // The match includes the bit arriving on this edge.
  assign hist_shift = {hist_q[SYNC_LEN-2:0], bit_in};
  assign word_shift = {word_q[WIDTH-2:0], bit_in};
  assign last_data  = (cnt_q == LAST_BIT);
  // A transfer on the commit edge frees the buffer for the new word.
  assign can_load   = !data_valid_q || data_ready;

`ifdef BIT_DEFRAMER_PARITY_EN
  logic parity_err_q;
  logic parity_err_d;

  always_comb begin
    commit       = 1'b0;
    data_out_d   = word_q;
    parity_err_d = 1'b0;
    if (bit_en && state_q == PARITY) begin
      commit       = 1'b1;
      parity_err_d = ^{word_q, bit_in};
    end
  end

  assign parity_err = parity_err_q;
`else
  always_comb begin
    commit     = 1'b0;
    data_out_d = word_shift;
    if (bit_en && state_q == DATA && last_data) begin
      commit = 1'b1;
    end
  end

  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      hist_q       <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef BIT_DEFRAMER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (data_valid_q && data_ready) begin
        data_valid_q <= 1'b0;
      end

      // Commit overrides the transfer-clear above when both happen together.
      if (commit) begin
        if (can_load) begin
          data_out_q   <= data_out_d;
          data_valid_q <= 1'b1;
`ifdef BIT_DEFRAMER_PARITY_EN
          parity_err_q <= parity_err_d;
`endif
        end else begin
          overflow_q <= 1'b1;
        end
      end

      if (bit_en) begin
        case (state_q)
          HUNT: begin
            if (hist_shift == SYNC) begin
              state_q <= DATA;
              hist_q  <= '0;
              cnt_q   <= '0;
            end else begin
              hist_q <= hist_shift;
            end
          end
          DATA: begin
            word_q <= word_shift[WW-1:0];
            if (last_data) begin
              cnt_q <= '0;
`ifdef BIT_DEFRAMER_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= HUNT;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != HUNT);

endmodule
